// File: rtl/alu_mode_sequencer.sv
// Buffers user mode codes in a FIFO, translates them to ALU opcodes and issues them one at a
// time, stalling after multiplies. Define MODE_REMAP_EN for a writable translation table.
module alu_mode_sequencer #(
    parameter int unsigned     MODE_W  = 4,
    parameter int unsigned     OP_W    = 4,
    parameter int unsigned     DEPTH   = 4,
    parameter int unsigned     MUL_LAT = 3,
    parameter logic [OP_W-1:0] MUL_OP  = OP_W'(4'b1100)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [MODE_W-1:0]      in_mode,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [OP_W-1:0]        out_op,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] fifo_cnt,
    output logic                   busy,
    output logic                   err_illegal,
    input  logic                   err_clr
`ifdef MODE_REMAP_EN
    ,
    input  logic                   tbl_we,
    input  logic [3:0]             tbl_addr,
    input  logic [OP_W-1:0]        tbl_data
`endif
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned WCNT_W = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_HOLD     = 2'd1;
    localparam logic [1:0] ST_MUL_WAIT = 2'd2;

    function automatic logic [3:0] f_default_op(input logic [3:0] mode);
        logic [3:0] op;
        unique case (mode)
            4'h0: op = 4'b1000;
            4'h1: op = 4'b1001;
            4'h2: op = 4'b0110;
            4'h3: op = 4'b0111;
            4'h4: op = 4'b1010;
            4'h5: op = 4'b1011;
            4'h6: op = 4'b1110;
            4'h7: op = 4'b1111;
            4'h8: op = 4'b1100;
            4'h9: op = 4'b1101;
            4'hA: op = 4'b0000;
            4'hB: op = 4'b0001;
            4'hC: op = 4'b0010;
            4'hD: op = 4'b0011;
            4'hE: op = 4'b0100;
            4'hF: op = 4'b0101;
        endcase
        return op;
    endfunction

    logic [OP_W-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_state;
    logic              r_out_valid;
    logic [OP_W-1:0]   r_out_op;
    logic [WCNT_W-1:0] r_wcnt;
    logic              r_err;

    logic [3:0]        w_mode4;
    logic              w_legal;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_fifo_nempty;
    logic              w_mul_hit;
    logic [OP_W-1:0]   w_xlate;
    logic [OP_W-1:0]   w_head;
    logic [1:0]        w_state_nxt;
    logic              w_out_valid_nxt;
    logic [OP_W-1:0]   w_out_op_nxt;
    logic [WCNT_W-1:0] w_wcnt_nxt;
    logic              w_err_nxt;

    assign w_mode4       = 4'(in_mode);
    assign w_legal       = ((in_mode >> 4) == '0);
    assign w_accept      = in_valid & in_ready;
    assign w_push        = w_accept & w_legal;
    assign w_fifo_nempty = (r_cnt != '0);
    assign w_head        = r_mem[r_rd_ptr];
    // With a single-cycle multiplier the stall collapses and MUL_OP issues like any other op.
    assign w_mul_hit     = (r_out_op == MUL_OP) && (MUL_LAT > 1);

`ifdef MODE_REMAP_EN
    logic [OP_W-1:0] r_tbl [16];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                r_tbl[i] <= OP_W'(f_default_op(4'(i)));
            end
        end else if (tbl_we) begin
            r_tbl[tbl_addr] <= tbl_data;
        end
    end

    assign w_xlate = r_tbl[w_mode4];
`else
    assign w_xlate = OP_W'(f_default_op(w_mode4));
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_out_valid_nxt = r_out_valid;
        w_out_op_nxt    = r_out_op;
        w_wcnt_nxt      = r_wcnt;
        w_pop           = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_fifo_nempty) begin
                    w_pop           = 1'b1;
                    w_out_op_nxt    = w_head;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    if (w_mul_hit) begin
                        w_out_valid_nxt = 1'b0;
                        w_wcnt_nxt      = WCNT_W'(MUL_LAT - 1);
                        w_state_nxt     = ST_MUL_WAIT;
                    end else if (w_fifo_nempty) begin
                        w_pop        = 1'b1;
                        w_out_op_nxt = w_head;
                    end else begin
                        w_out_valid_nxt = 1'b0;
                        w_state_nxt     = ST_IDLE;
                    end
                end
            end
            ST_MUL_WAIT: begin
                w_wcnt_nxt = r_wcnt - WCNT_W'(1);
                if (r_wcnt == WCNT_W'(1)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_out_valid_nxt = 1'b0;
                w_state_nxt     = ST_IDLE;
            end
        endcase
    end

    // A new illegal accept outranks a simultaneous clear.
    always_comb begin
        w_err_nxt = r_err;
        if (w_accept && !w_legal) begin
            w_err_nxt = 1'b1;
        end else if (err_clr) begin
            w_err_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_cnt       <= '0;
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_out_op    <= '0;
            r_wcnt      <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_cnt       <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
            r_state     <= w_state_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_op    <= w_out_op_nxt;
            r_wcnt      <= w_wcnt_nxt;
            r_err       <= w_err_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_xlate;
        end
    end

    assign in_ready    = (r_cnt != CNT_W'(DEPTH));
    assign out_valid   = r_out_valid;
    assign out_op      = r_out_op;
    assign fifo_cnt    = r_cnt;
    assign busy        = w_fifo_nempty | r_out_valid | (r_state == ST_MUL_WAIT);
    assign err_illegal = r_err;

endmodule

// File: tb/tb_alu_mode_sequencer.sv
// Randomised and directed bench for alu_mode_sequencer against a queue-based behavioural model.
// Covers the MODE_REMAP_EN table when that macro is defined.
module tb_alu_mode_sequencer;

    localparam int unsigned     MODE_W  = 5;
    localparam int unsigned     OP_W    = 4;
    localparam int unsigned     DEPTH   = 4;
    localparam int unsigned     MUL_LAT = 3;
    localparam logic [OP_W-1:0] MUL_OP  = 4'b1100;
    localparam int unsigned     CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [3:0] DEF_TBL [16] = '{4'h8, 4'h9, 4'h6, 4'h7, 4'hA, 4'hB, 4'hE, 4'hF,
                                            4'hC, 4'hD, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5};

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [MODE_W-1:0] in_mode;
    logic              in_ready;
    logic              out_valid;
    logic [OP_W-1:0]   out_op;
    logic              out_ready;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              busy;
    logic              err_illegal;
    logic              err_clr;
    logic              tbl_we;
    logic [3:0]        tbl_addr;
    logic [OP_W-1:0]   tbl_data;

    always #5 clk = ~clk;

    alu_mode_sequencer #(
        .MODE_W (MODE_W),
        .OP_W   (OP_W),
        .DEPTH  (DEPTH),
        .MUL_LAT(MUL_LAT),
        .MUL_OP (MUL_OP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_mode    (in_mode),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_op     (out_op),
        .out_ready  (out_ready),
        .fifo_cnt   (fifo_cnt),
        .busy       (busy),
        .err_illegal(err_illegal),
        .err_clr    (err_clr)
`ifdef MODE_REMAP_EN
        ,
        .tbl_we     (tbl_we),
        .tbl_addr   (tbl_addr),
        .tbl_data   (tbl_data)
`endif
    );

    // Model: sb holds every opcode accepted and not yet handed to the ALU, head first.
    // When m_valid is set the head sits in the output register, the rest in the FIFO.
    logic [OP_W-1:0] ref_tbl [16];
    logic [OP_W-1:0] sb [$];
    bit              m_valid;
    int              m_wait;
    bit              m_err;

    int              total = 0;
    int              bad   = 0;
    bit              e_valid;
    bit              e_ready;
    logic [OP_W-1:0] e_op;
    logic [6:0]      e_vec;

    function automatic logic [6:0] obs_vec();
        return {out_valid, in_ready, fifo_cnt, busy, err_illegal};
    endfunction

    task automatic model_reset();
        sb.delete();
        m_valid = 1'b0;
        m_wait  = 0;
        m_err   = 1'b0;
        for (int i = 0; i < 16; i++) ref_tbl[i] = OP_W'(DEF_TBL[i]);
    endtask

    task automatic drive(input bit iv, input logic [MODE_W-1:0] im, input bit ordy, input bit eclr,
                         input bit twe = 1'b0, input logic [3:0] ta = '0,
                         input logic [OP_W-1:0] td = '0);
        int n_fifo;
        in_valid  = iv;
        in_mode   = im;
        out_ready = ordy;
        err_clr   = eclr;
        tbl_we    = twe;
        tbl_addr  = ta;
        tbl_data  = td;
        n_fifo    = sb.size() - int'(m_valid);
        e_valid   = m_valid;
        e_ready   = (n_fifo != DEPTH);
        e_op      = m_valid ? sb[0] : '0;
        e_vec     = {m_valid, e_ready, CNT_W'(n_fifo), (sb.size() != 0) || (m_wait > 0), m_err};
    endtask

    task automatic advance();
        bit              acc;
        logic [OP_W-1:0] op;
        acc = in_valid && ((sb.size() - int'(m_valid)) != DEPTH);
        if (m_valid) begin
            if (out_ready) begin
                op = sb.pop_front();
                if (op == MUL_OP && MUL_LAT > 1) begin
                    m_valid = 1'b0;
                    m_wait  = MUL_LAT - 1;
                end else begin
                    m_valid = (sb.size() != 0);
                end
            end
        end else if (m_wait > 0) begin
            m_wait--;
        end else begin
            m_valid = (sb.size() != 0);
        end
        if (acc && in_mode < 16) sb.push_back(ref_tbl[in_mode[3:0]]);
        if (acc && in_mode >= 16) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
        if (tbl_we) ref_tbl[tbl_addr] = tbl_data;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 1'b0;
        drive(0, '0, 0, 0);
        repeat (2) @(negedge clk);
        total++;
        if (obs_vec() !== e_vec) begin
            bad++;
            $display("FAIL reset_hold got=%b exp=%b", obs_vec(), e_vec);
        end
        total++;
        if (out_op !== e_op) begin
            bad++;
            $display("FAIL reset_op got=%h exp=%h", out_op, e_op);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive(0, '0, 0, 0);
            total++;
            if (obs_vec() !== e_vec) begin
                bad++;
                $display("FAIL reset_idle c=%0d got=%b exp=%b", c, obs_vec(), e_vec);
            end
            advance();
        end
    endtask

    task automatic test_stream();
        int              idx = 0;
        logic [OP_W-1:0] got [$];
        for (int c = 0; c < 150 && (idx < 16 || sb.size() != 0 || m_wait > 0); c++) begin
            drive(idx < 16, MODE_W'(idx), 1, 0);
            total++;
            if (obs_vec() !== e_vec) begin
                bad++;
                $display("FAIL stream_state c=%0d got=%b exp=%b", c, obs_vec(), e_vec);
            end
            if (e_valid) begin
                total++;
                if (out_op !== e_op) begin
                    bad++;
                    $display("FAIL stream_op c=%0d got=%h exp=%h", c, out_op, e_op);
                end
            end
            if (out_valid && out_ready) got.push_back(out_op);
            if (idx < 16 && e_ready) idx++;
            advance();
        end
        total++;
        if (got.size() != 16) begin
            bad++;
            $display("FAIL stream_count got=%0d exp=16", got.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                total++;
                if (got[i] !== OP_W'(DEF_TBL[i])) begin
                    bad++;
                    $display("FAIL stream_seq i=%0d got=%h exp=%h", i, got[i], DEF_TBL[i]);
                end
            end
        end
        drive(0, '0, 1, 0);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL stream_busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_full();
        int pushed = 0;
        int hs     = 0;
        for (int c = 0; c < 8; c++) begin
            drive(pushed < 5, MODE_W'($urandom_range(0, 15)), 0, 0);
            total++;
            if (obs_vec() !== e_vec) begin
                bad++;
                $display("FAIL full_fill c=%0d got=%b exp=%b", c, obs_vec(), e_vec);
            end
            if (pushed < 5 && e_ready) pushed++;
            advance();
        end
        drive(1, 5'h3, 0, 0);
        total++;
        if ({out_valid, in_ready, fifo_cnt} !== {1'b1, 1'b0, CNT_W'(4)}) begin
            bad++;
            $display("FAIL full_level got v=%b rdy=%b cnt=%0d exp v=1 rdy=0 cnt=4",
                     out_valid, in_ready, fifo_cnt);
        end
        advance();
        for (int c = 0; c < 30; c++) begin
            drive(0, '0, 1, 0);
            total++;
            if (obs_vec() !== e_vec) begin
                bad++;
                $display("FAIL full_drain c=%0d got=%b exp=%b", c, obs_vec(), e_vec);
            end
            if (e_valid) begin
                total++;
                if (out_op !== e_op) begin
                    bad++;
                    $display("FAIL full_op c=%0d got=%h exp=%h", c, out_op, e_op);
                end
            end
            if (out_valid && out_ready) hs++;
            advance();
        end
        total++;
        if (hs != 5) begin
            bad++;
            $display("FAIL full_handshakes got=%0d exp=5", hs);
        end
    endtask

    task automatic test_mul_pair();
        int pushed = 0;
        int hs_at [$];
        for (int c = 0; c < 20; c++) begin
            drive(pushed < 2, 5'h8, 1, 0);
            total++;
            if (obs_vec() !== e_vec) begin
                bad++;
                $display("FAIL mul_state c=%0d got=%b exp=%b", c, obs_vec(), e_vec);
            end
            if (out_valid && out_ready) hs_at.push_back(c);
            if (pushed < 2 && e_ready) pushed++;
            advance();
        end
        total++;
        if (hs_at.size() != 2) begin
            bad++;
            $display("FAIL mul_count got=%0d exp=2", hs_at.size());
        end else if (hs_at[1] - hs_at[0] != MUL_LAT + 1) begin
            bad++;
            $display("FAIL mul_spacing got=%0d exp=%0d", hs_at[1] - hs_at[0], MUL_LAT + 1);
        end
        drive(0, '0, 1, 0);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL mul_busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_illegal();
        drive(1, 5'h13, 1, 0);
        advance();
        for (int c = 0; c < 3; c++) begin
            drive(0, '0, 1, 0);
            total++;
            if (obs_vec() !== e_vec) begin
                bad++;
                $display("FAIL illegal_state c=%0d got=%b exp=%b", c, obs_vec(), e_vec);
            end
            advance();
        end
        drive(0, '0, 1, 1);
        total++;
        if ({err_illegal, fifo_cnt, out_valid} !== {1'b1, CNT_W'(0), 1'b0}) begin
            bad++;
            $display("FAIL illegal_flag got err=%b cnt=%0d v=%b exp err=1 cnt=0 v=0",
                     err_illegal, fifo_cnt, out_valid);
        end
        advance();
        drive(1, 5'h1F, 1, 1);
        total++;
        if (err_illegal !== 1'b0) begin
            bad++;
            $display("FAIL illegal_clear got=%b exp=0", err_illegal);
        end
        advance();
        drive(0, '0, 1, 0);
        total++;
        if (obs_vec() !== e_vec) begin
            bad++;
            $display("FAIL illegal_set_wins got=%b exp=%b", obs_vec(), e_vec);
        end
        advance();
        drive(0, '0, 1, 1);
        advance();
    endtask

    task automatic test_random();
        logic [MODE_W-1:0] md;
        for (int c = 0; c < 460; c++) begin
            if (c < 400) begin
                md = ($urandom_range(0, 7) == 0) ? MODE_W'(16 + $urandom_range(0, 15))
                                                 : MODE_W'($urandom_range(0, 15));
                drive($urandom_range(0, 3) != 0, md, $urandom_range(0, 3) != 0,
                      $urandom_range(0, 15) == 0);
            end else begin
                drive(0, '0, 1, 0);
            end
            total++;
            if (obs_vec() !== e_vec) begin
                bad++;
                $display("FAIL random_state c=%0d got=%b exp=%b", c, obs_vec(), e_vec);
            end
            if (e_valid) begin
                total++;
                if (out_op !== e_op) begin
                    bad++;
                    $display("FAIL random_op c=%0d got=%h exp=%h", c, out_op, e_op);
                end
            end
            advance();
        end
    endtask

    task automatic test_reset_midwait();
        bit         st_iv [6] = '{1, 1, 1, 1, 0, 0};
        logic [4:0] st_md [6] = '{5'h8, 5'h0, 5'h1, 5'h2, 5'h0, 5'h0};
        bit         st_or [6] = '{0, 0, 0, 0, 1, 0};
        for (int i = 0; i < 6; i++) begin
            drive(st_iv[i], st_md[i], st_or[i], 0);
            total++;
            if (obs_vec() !== e_vec) begin
                bad++;
                $display("FAIL midwait_setup i=%0d got=%b exp=%b", i, obs_vec(), e_vec);
            end
            advance();
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({obs_vec(), out_op} !== {7'b0100000, OP_W'(0)}) begin
            bad++;
            $display("FAIL midwait_async got=%b op=%h exp=0100000 op=0", obs_vec(), out_op);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            drive(0, '0, 1, 0);
            total++;
            if (obs_vec() !== e_vec || out_op !== '0) begin
                bad++;
                $display("FAIL midwait_stale c=%0d got=%b op=%h exp=%b op=0",
                         c, obs_vec(), out_op, e_vec);
            end
            advance();
        end
    endtask

`ifdef MODE_REMAP_EN
    task automatic test_remap();
        logic [MODE_W-1:0] modes [3] = '{5'h4, 5'h5, 5'h5};
        logic [OP_W-1:0]   ops [$];
        int                hs_at [$];
        int                pushed = 0;
        drive(0, '0, 1, 0, 1, 4'd4, 4'b1100);
        advance();
        for (int c = 0; c < 24; c++) begin
            // The second accept shares its edge with a write to entry 5 and must see the old value.
            drive(pushed < 3, (pushed < 3) ? modes[pushed] : '0, 1, 0, pushed == 1, 4'd5, 4'h0);
            total++;
            if (obs_vec() !== e_vec) begin
                bad++;
                $display("FAIL remap_state c=%0d got=%b exp=%b", c, obs_vec(), e_vec);
            end
            if (out_valid && out_ready) begin
                ops.push_back(out_op);
                hs_at.push_back(c);
            end
            if (pushed < 3 && e_ready) pushed++;
            advance();
        end
        total++;
        if (ops.size() != 3) begin
            bad++;
            $display("FAIL remap_count got=%0d exp=3", ops.size());
        end else if ({ops[0], ops[1], ops[2]} !== {4'hC, 4'hB, 4'h0}) begin
            bad++;
            $display("FAIL remap_ops got=%h,%h,%h exp=c,b,0", ops[0], ops[1], ops[2]);
        end else if (hs_at[1] - hs_at[0] != MUL_LAT + 1) begin
            bad++;
            $display("FAIL remap_stall got=%0d exp=%0d", hs_at[1] - hs_at[0], MUL_LAT + 1);
        end
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_mode   = '0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        tbl_we    = 1'b0;
        tbl_addr  = '0;
        tbl_data  = '0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_stream();
        test_full();
        test_mul_pair();
        test_illegal();
        test_random();
        test_reset_midwait();
`ifdef MODE_REMAP_EN
        test_remap();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
